// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU (add/sub/not/or-reduce) with overflow, zero and op counter; ALU_SAT_EN clamps add/sub results.
// Latency 2 cycles, 1 op/cycle; holds up to 2 ops, in_ready drops only when both stages are full and S2 is not draining.
module alu_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       Opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   C,
    output logic             ovf,
    output logic             zero,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

`ifdef ALU_SAT_EN
    localparam logic [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] SAT_MIN = {2'b11, {(WIDTH-1){1'b0}}};
`endif

    logic             r_s1_vld;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s2_vld;
    logic [WIDTH:0]   r_c;
    logic             r_ovf;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_drain;
    logic             w_s2_ld_en;
    logic             w_in_xfer;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_res;
    logic             w_ovf;
    logic             w_zero;

    assign w_s2_drain = r_s2_vld && out_ready;
    assign w_s2_ld_en = !r_s2_vld || w_s2_drain;
    assign in_ready   = !r_s1_vld || w_s2_ld_en;
    assign w_in_xfer  = in_valid && in_ready;

    assign w_a_ext = {r_a[WIDTH-1], r_a};
    assign w_b_ext = {r_b[WIDTH-1], r_b};
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_diff  = w_a_ext - w_b_ext;

    // The WIDTH+1-bit result is exact, so it is out of WIDTH-bit range iff its top two bits differ.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            OP_NOT: w_res = ~w_a_ext;
            OP_ROR: w_res = {{WIDTH{1'b0}}, |r_b};
        endcase
`ifdef ALU_SAT_EN
        if (w_ovf) begin
            w_res = w_res[WIDTH] ? SAT_MIN : SAT_MAX;
        end
`endif
        w_zero = (w_res == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_s2_vld <= 1'b0;
            r_c      <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (in_ready) begin
                r_s1_vld <= in_valid;
            end
            if (w_in_xfer) begin
                r_op <= Opcode;
                r_a  <= A;
                r_b  <= B;
            end
            if (w_s2_ld_en) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s2_ld_en && r_s1_vld) begin
                r_c    <= w_res;
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
            if (w_s2_drain) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign C         = r_c;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign ops_done  = r_cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=4 with a 4-bit counter so ops_done wraps.
module tb_alu_pipe;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       Opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   C;
    logic             ovf;
    logic             zero;
    logic [CNT_W-1:0] ops_done;

    int tests;
    int fails;
    int exp_cnt;

    alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .ovf(ovf), .zero(zero), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Integer reference: {C, ovf, zero}
    function automatic logic [WIDTH+2:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        int ia, ib, r;
        logic o;
        ia = int'($signed(a));
        ib = int'($signed(b));
        case (op)
            2'b00:   r = ia + ib;
            2'b01:   r = ia - ib;
            2'b10:   r = -ia - 1;
            default: r = (b != '0) ? 1 : 0;
        endcase
        o = (op[1] == 1'b0) && (r > 7 || r < -8);
`ifdef ALU_SAT_EN
        if (o) r = (r > 7) ? 7 : -8;
`endif
        return {5'(r), o, (r == 0)};
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if ({in_ready, out_valid, C, ovf, zero, ops_done} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL reset_values got rdy=%b vld=%b C=%b ovf=%b z=%b cnt=%0d exp rdy=1 vld=0 C=0 ovf=0 z=0 cnt=0",
                     in_ready, out_valid, C, ovf, zero, ops_done);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_arith();
        logic [1:0] v_op [10];
        logic [3:0] v_a [10];
        logic [3:0] v_b [10];
        logic [4:0] v_c [10];
        logic       v_ovf [10];
        logic       v_zero [10];
        v_op   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
        v_a    = '{4'd7, 4'h8, 4'd3, 4'd5, 4'd0, 4'd0, 4'h8, 4'd3, 4'd7, 4'hF};
        v_b    = '{4'd1, 4'd1, 4'd3, 4'd0, 4'd0, 4'h8, 4'h8, 4'hD, 4'hF, 4'd0};
`ifdef ALU_SAT_EN
        v_c    = '{5'b00111, 5'b11000, 5'b00000, 5'b11010, 5'b00000, 5'b00001, 5'b11000, 5'b00000, 5'b00111, 5'b00000};
`else
        v_c    = '{5'b01000, 5'b10111, 5'b00000, 5'b11010, 5'b00000, 5'b00001, 5'b10000, 5'b00000, 5'b01000, 5'b00000};
`endif
        v_ovf  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        v_zero = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            Opcode = v_op[i]; A = v_a[i]; B = v_b[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL arith[%0d]_early_valid got %b exp 0", i, out_valid);
            end
            @(negedge clk);
            tests++;
            if ({out_valid, C, ovf, zero} !== {1'b1, v_c[i], v_ovf[i], v_zero[i]}) begin
                fails++;
                $display("FAIL arith[%0d] got vld=%b C=%b ovf=%b z=%b exp vld=1 C=%b ovf=%b z=%b",
                         i, out_valid, C, ovf, zero, v_c[i], v_ovf[i], v_zero[i]);
            end
            exp_cnt++;
        end
        @(negedge clk);
        tests++;
        if (ops_done !== exp_cnt[3:0]) begin
            fails++;
            $display("FAIL arith_ops_done got %0d exp %0d", ops_done, exp_cnt[3:0]);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(negedge clk);
        Opcode = 2'b00; A = 4'd1; B = 4'd2; in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy_first got %b exp 1", in_ready); end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy_second got %b exp 1", in_ready); end
        Opcode = 2'b01; A = 4'd2; B = 4'd5;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, C} !== {1'b0, 1'b1, 5'b00011}) begin
            fails++;
            $display("FAIL bp_full got rdy=%b vld=%b C=%b exp rdy=0 vld=1 C=00011", in_ready, out_valid, C);
        end
        Opcode = 2'b10; A = 4'd0; B = 4'd0;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, C, ovf, zero} !== {1'b0, 1'b1, 5'b00011, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bp_hold got rdy=%b vld=%b C=%b ovf=%b z=%b exp rdy=0 vld=1 C=00011 ovf=0 z=0",
                     in_ready, out_valid, C, ovf, zero);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy_on_drain got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        exp_cnt++;
        tests++;
        if ({out_valid, C} !== {1'b1, 5'b11101}) begin
            fails++;
            $display("FAIL bp_second_result got vld=%b C=%b exp vld=1 C=11101", out_valid, C);
        end
        @(negedge clk);
        exp_cnt++;
        tests++;
        if ({out_valid, C} !== {1'b1, 5'b11111}) begin
            fails++;
            $display("FAIL bp_third_result got vld=%b C=%b exp vld=1 C=11111", out_valid, C);
        end
        @(negedge clk);
        exp_cnt++;
        tests++;
        if ({out_valid, ops_done} !== {1'b0, exp_cnt[3:0]}) begin
            fails++;
            $display("FAIL bp_done got vld=%b cnt=%0d exp vld=0 cnt=%0d", out_valid, ops_done, exp_cnt[3:0]);
        end
    endtask

    task automatic test_stream();
        logic [WIDTH+2:0] q[$];
        logic [WIDTH+2:0] e;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                e = q.pop_front();
                tests++;
                if ({out_valid, C, ovf, zero} !== {1'b1, e}) begin
                    fails++;
                    $display("FAIL stream[%0d] got vld=%b C=%b ovf=%b z=%b exp vld=1 C=%b ovf=%b z=%b",
                             cyc - 2, out_valid, C, ovf, zero, e[6:2], e[1], e[0]);
                end
                exp_cnt++;
            end
            if (cyc < 20) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_rdy[%0d] got %b exp 1", cyc, in_ready);
                end
                Opcode = 2'($urandom_range(0, 3));
                A = 4'($urandom_range(0, 15));
                B = 4'($urandom_range(0, 15));
                in_valid = 1'b1;
                q.push_back(model(Opcode, A, B));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if ({out_valid, ops_done} !== {1'b0, exp_cnt[3:0]}) begin
            fails++;
            $display("FAIL stream_done got vld=%b cnt=%0d exp vld=0 cnt=%0d", out_valid, ops_done, exp_cnt[3:0]);
        end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        @(negedge clk);
        Opcode = 2'b00; A = 4'd1; B = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        A = 4'd2; B = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, C, ovf, zero, ops_done} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL midop_reset got rdy=%b vld=%b C=%b ovf=%b z=%b cnt=%0d exp rdy=1 vld=0 C=0 ovf=0 z=0 cnt=0",
                     in_ready, out_valid, C, ovf, zero, ops_done);
        end
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        Opcode = 2'b00; A = 4'd2; B = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midop_early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        tests++;
        if ({out_valid, C, ovf, zero} !== {1'b1, 5'b00101, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL midop_result got vld=%b C=%b ovf=%b z=%b exp vld=1 C=00101 ovf=0 z=0",
                     out_valid, C, ovf, zero);
        end
        exp_cnt++;
        @(negedge clk);
        tests++;
        if ({out_valid, ops_done} !== {1'b0, exp_cnt[3:0]}) begin
            fails++;
            $display("FAIL midop_done got vld=%b cnt=%0d exp vld=0 cnt=%0d", out_valid, ops_done, exp_cnt[3:0]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 0;
        clk = 1'b0;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        Opcode = 2'b00;
        A = '0;
        B = '0;
        test_reset();
        test_arith();
        test_backpressure();
        test_stream();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
